// File: rtl/ftdi_pkg.sv
// Shared types and FTDI async-FIFO timing defaults for the USB FIFO bridge.
package ftdi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_RD_PULSE,
    ST_RECOVER
  } state_t;

  localparam int FTDI_WR_CYC    = 2;
  localparam int FTDI_RD_CYC    = 2;
  localparam int FTDI_RECOV_CYC = 1;
  localparam int CNT_W          = 8;

endpackage

// File: rtl/ftdi_pkt_assembler.sv
// Collects read bytes into a wide packet register and runs the packet valid/ready handshake.
module ftdi_pkt_assembler #(
  parameter int PKT_BYTES = 8,
  parameter int CT_W      = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   store,
  input  logic [7:0]             din,
  input  logic [CT_W-1:0]        pkt_len,
  input  logic                   pkt_ready,
  output logic [PKT_BYTES*8-1:0] pkt_data,
  output logic                   pkt_valid,
  output logic [CT_W-1:0]        rd_ct,
  output logic                   room
);

  localparam int IDX_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

  logic [PKT_BYTES-1:0][7:0] lanes;
  logic [CT_W-1:0]           ct_next, len_eff;
  logic                      accept;

  assign len_eff  = (pkt_len > CT_W'(PKT_BYTES)) ? CT_W'(PKT_BYTES) : pkt_len;
  assign room     = rd_ct < len_eff;
  assign accept   = pkt_valid & pkt_ready;
  assign pkt_data = lanes;

  always_comb begin
    ct_next = rd_ct;
    if (clear || accept)   ct_next = '0;
    else if (store && room) ct_next = rd_ct + 1'b1;
  end

  // valid registered from the next count so it drops in the same cycle rd_ct clears
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ct     <= '0;
      pkt_valid <= 1'b0;
      lanes     <= '0;
    end else begin
      rd_ct     <= ct_next;
      pkt_valid <= (len_eff != '0) && (ct_next == len_eff);
      if (clear || accept)    lanes <= '0;
      else if (store && room) lanes[rd_ct[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ftdi_fifo_bridge.sv
// FT232H/FT2232H async-FIFO bridge: strobe timing FSM with round-robin read/write grant.
module ftdi_fifo_bridge
  import ftdi_pkg::*;
#(
  parameter int PKT_BYTES = 8,
  parameter int CT_W      = 4,
  parameter int WR_CYC    = FTDI_WR_CYC,
  parameter int RD_CYC    = FTDI_RD_CYC,
  parameter int RECOV_CYC = FTDI_RECOV_CYC
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   rxf_n,
  input  logic                   txe_n,
  input  logic [7:0]             adbus_in,
  output logic [7:0]             adbus_out,
  output logic                   adbus_oe,
  output logic                   rd_n,
  output logic                   wr_n,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [CT_W-1:0]        pkt_len,
  output logic [PKT_BYTES*8-1:0] pkt_data,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic [CT_W-1:0]        rd_ct,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] WR_LD = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LD = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] RC_LD = CNT_W'((RECOV_CYC == 0) ? 0 : RECOV_CYC - 1);
  localparam state_t AFTER_STB = (RECOV_CYC == 0) ? ST_IDLE : ST_RECOVER;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       wdata;
  logic             last_wr, last_wr_next;
  logic             load_wdata, store, room, rd_req, wr_req;

  assign rd_req = rd_en & ~rxf_n & room;
  assign wr_req = wr_en & ~txe_n & tx_valid;

  always_comb begin
    state_next   = state;
    cnt_next     = (cnt != '0) ? cnt - 1'b1 : '0;
    last_wr_next = last_wr;
    load_wdata   = 1'b0;
    store        = 1'b0;
    tx_ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        // on contention, grant whichever direction did not win last time
        if (rd_req && (!wr_req || last_wr)) begin
          state_next   = ST_RD_PULSE;
          cnt_next     = RD_LD;
          last_wr_next = 1'b0;
        end else if (wr_req) begin
          state_next   = ST_WR_SETUP;
          last_wr_next = 1'b1;
          load_wdata   = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        state_next = ST_WR_PULSE;
        cnt_next   = WR_LD;
      end
      ST_WR_PULSE: if (cnt == '0) begin
        tx_ready   = 1'b1;
        state_next = AFTER_STB;
        cnt_next   = RC_LD;
      end
      ST_RD_PULSE: if (cnt == '0) begin
        store      = 1'b1;
        state_next = AFTER_STB;
        cnt_next   = RC_LD;
      end
      ST_RECOVER: if (cnt == '0) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (clear) begin
      state_next   = ST_IDLE;
      cnt_next     = '0;
      last_wr_next = 1'b1;
      load_wdata   = 1'b0;
      store        = 1'b0;
      tx_ready     = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      last_wr <= 1'b1;
      wdata   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      last_wr <= last_wr_next;
      if (clear)           wdata <= '0;
      else if (load_wdata) wdata <= tx_data;
    end
  end

  assign rd_n      = (state != ST_RD_PULSE);
  assign wr_n      = (state != ST_WR_PULSE);
  assign adbus_oe  = (state == ST_WR_SETUP) || (state == ST_WR_PULSE);
  assign adbus_out = adbus_oe ? wdata : 8'h00;
  assign busy      = (state != ST_IDLE);

  ftdi_pkt_assembler #(.PKT_BYTES(PKT_BYTES), .CT_W(CT_W)) u_asm (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .store     (store),
    .din       (adbus_in),
    .pkt_len   (pkt_len),
    .pkt_ready (pkt_ready),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .rd_ct     (rd_ct),
    .room      (room)
  );

endmodule
